// File: rtl/fir_mac_sequencer.sv
// Sequenced multiply-accumulate stage of the FIR filter: one accepted sample
// starts a TAPS-cycle MAC walk over the sample window, then holds the result until taken.
module fir_mac_sequencer #(
   parameter int DATA_W = 8,
   parameter int TAPS   = 8,
   parameter int IDX_W  = 3,
   parameter int ACC_W  = 19
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic [IDX_W-1:0]         coeff_addr,
   input  logic signed [DATA_W-1:0] coeff_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_data,
   output logic                     busy
);

   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DONE
   } state_t;

   state_t                    state;
   logic signed [DATA_W-1:0]  x_win [TAPS];
   logic [IDX_W-1:0]          tap;
   logic signed [ACC_W-1:0]   acc;
   logic signed [PROD_W-1:0]  prod;

   // Operands are widened first so the product keeps full signed precision.
   assign prod       = PROD_W'(x_win[tap]) * PROD_W'(coeff_in);
   assign coeff_addr = (state == MAC) ? tap : '0;
   assign out_data   = acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         for (int k = 0; k < TAPS; k++) begin
            x_win[k] <= '0;
         end
         tap       <= '0;
         acc       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_win[0] <= in_data;
                  for (int k = 1; k < TAPS; k++) begin
                     x_win[k] <= x_win[k-1];
                  end
                  acc      <= '0;
                  tap      <= '0;
                  state    <= MAC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            MAC: begin
               acc <= acc + ACC_W'(prod);
               tap <= tap + 1'b1;
               // The last tap's product lands in acc on this same edge.
               if (tap == IDX_W'(TAPS - 1)) begin
                  state     <= DONE;
                  tap       <= '0;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: impulse, extremes, backpressure,
// mid-MAC reset and streaming, each result hand-computed from the window contents.
module tb_fir_mac_sequencer;

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic signed [7:0]   in_data;
   logic [2:0]          coeff_addr;
   logic signed [7:0]   coeff_in;
   logic                out_valid;
   logic                out_ready;
   logic signed [18:0]  out_data;
   logic                busy;

   logic signed [7:0]   coefTab [8];
   int                  cmpCount;
   int                  errCount;

   fir_mac_sequencer #(
      .DATA_W(8),
      .TAPS(8),
      .IDX_W(3),
      .ACC_W(19)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .coeff_addr(coeff_addr),
      .coeff_in(coeff_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Coefficient select model: the tap index picks one entry, same cycle.
   always_comb coeff_in = coefTab[coeff_addr];

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic v, input logic signed [7:0] d, input logic r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
   endtask

   task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
      cmpCount++;
      assert (obs === exp)
      else begin
         errCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic setCoefRamp();
      for (int k = 0; k < 8; k++) coefTab[k] = 8'(k + 1);
   endtask

   task automatic setCoefConst(input logic signed [7:0] c);
      for (int k = 0; k < 8; k++) coefTab[k] = c;
   endtask

   // Starts at a negedge in IDLE; returns at a negedge back in IDLE.
   task automatic runSample(input string tag, input logic signed [7:0] d,
                            input logic signed [31:0] exp, input int holdCycles);
      checkOutput({tag, ".in_ready"}, in_ready, 1);
      applyStimulus(1'b1, d, holdCycles == 0);
      @(negedge clk);
      applyStimulus(1'b0, 8'sd0, holdCycles == 0);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("%s.addr%0d", tag, k), coeff_addr, k);
         checkOutput($sformatf("%s.noval%0d", tag, k), out_valid, 0);
         @(negedge clk);
      end
      checkOutput({tag, ".out_valid"}, out_valid, 1);
      checkOutput({tag, ".out_data"}, out_data, exp);
      if (holdCycles > 0) begin
         applyStimulus(1'b1, 8'sd55, 1'b0);
         for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput($sformatf("%s.hold_valid%0d", tag, h), out_valid, 1);
            checkOutput($sformatf("%s.hold_data%0d", tag, h), out_data, exp);
            checkOutput($sformatf("%s.hold_ready%0d", tag, h), in_ready, 0);
         end
         applyStimulus(1'b0, 8'sd0, 1'b1);
      end
      @(negedge clk);
      checkOutput({tag, ".idle_ready"}, in_ready, 1);
      checkOutput({tag, ".idle_valid"}, out_valid, 0);
   endtask

   initial begin
      int firstIdx;
      int lastIdx;
      int nOut;

      cmpCount = 0;
      errCount = 0;
      setCoefRamp();
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'sd0, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("rst.out_valid", out_valid, 0);
      checkOutput("rst.in_ready", in_ready, 1);
      checkOutput("rst.busy", busy, 0);
      checkOutput("rst.out_data", out_data, 0);
      checkOutput("rst.coeff_addr", coeff_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] impulse response");
      runSample("imp0", 8'sd1, 1, 0);
      for (int n = 1; n <= 8; n++) begin
         runSample($sformatf("imp%0d", n), 8'sd0, (n < 8) ? n + 1 : 0, 0);
      end

      $display("[TB] extremes");
      setCoefConst(-8'sd128);
      for (int n = 1; n <= 8; n++) begin
         runSample($sformatf("neg%0d", n), -8'sd128, n * 16384, 0);
      end
      for (int m = 1; m <= 8; m++) begin
         runSample($sformatf("pos%0d", m), 8'sd127, -128 * (255 * m - 1024), 0);
      end

      $display("[TB] backpressure");
      runSample("bp", 8'sd0, -113792, 5);
      setCoefRamp();
      runSample("bp_after", 8'sd0, 4191, 0);

      $display("[TB] reset mid-MAC");
      applyStimulus(1'b1, 8'sd3, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 8'sd0, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("mrst.tap4", coeff_addr, 4);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("mrst.busy", busy, 0);
      checkOutput("mrst.in_ready", in_ready, 1);
      checkOutput("mrst.out_valid", out_valid, 0);
      checkOutput("mrst.out_data", out_data, 0);
      checkOutput("mrst.coeff_addr", coeff_addr, 0);
      runSample("mrst_imp0", 8'sd1, 1, 0);
      runSample("mrst_imp1", 8'sd0, 2, 0);

      $display("[TB] streaming");
      firstIdx = -1;
      lastIdx  = -1;
      nOut     = 0;
      applyStimulus(1'b1, 8'sd0, 1'b1);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if ((i % 10) < 8) begin
            checkOutput($sformatf("str.addr%0d", i), coeff_addr, i % 10);
         end
         if (out_valid) begin
            checkOutput($sformatf("str.data%0d", i), out_data, 3 + nOut);
            if (nOut == 0) firstIdx = i;
            else checkOutput($sformatf("str.gap%0d", i), i - lastIdx, 10);
            lastIdx = i;
            nOut++;
         end
      end
      applyStimulus(1'b0, 8'sd0, 1'b1);
      checkOutput("str.count", nOut, 3);
      checkOutput("str.latency", firstIdx, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
